decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage with a valid/ready handshake on both sides and a 2-entry skid buffer.
- Sits between fetch and execute.
- Extends plain field extraction with:
  - format-selected immediate
  - illegal-instruction detection
  - optional M-extension classification
  - PC pass-through
  - pipeline flush

Parameters:
- XLEN, 32, datapath and PC width.
- ENABLE_M, 0, 1 = accept OP opcode with funct7=0000001 as MUL/DIV; 0 = such encodings are illegal.
- ENABLE_FENCE, 1, 1 = MISC-MEM (0001111) with funct3 000/001 legal (treated as NOP class); 0 = illegal.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all held instructions.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept; depends only on registered state.
- in_instr  input  32  raw instruction bits.
- in_pc  input  XLEN  instruction address.
- out_valid  output  1  out_pkt is valid.
- out_ready  input  1  execute accepts out_pkt.
- out_pkt  output  decode_packet_t  carries:
  - opcode, rd, rs1, rs2, funct3, funct7
  - imm (XLEN)
  - imm_fmt
  - is_muldiv
  - illegal
  - pc

Behaviour:
- Reset, asynchronous on rst_n low:
  - both buffer entries invalid
  - out_valid=0, in_ready=1
  - out_pkt=all zeros
- Transfers: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Storage:
  - Main register feeds out_pkt.
  - Skid register catches one extra packet when in_ready was 1 but the main register could not drain.
- Latency and throughput: accepted instruction appears on out_pkt the next cycle (latency 1). Throughput is 1/cycle when out_ready stays high.
- State is encoded by valid bits:
  - EMPTY (main invalid): in_ready=1.
  - ONE (main valid, skid invalid): in_ready=1.
  - FULL (both valid): in_ready=0.
- Transitions:
  - EMPTY+in → ONE.
  - ONE+in+out → ONE.
  - ONE+in+!out → FULL.
  - ONE+!in+out → EMPTY.
  - FULL+out → ONE (skid moves to main).
- in_ready is registered and equals !skid_valid. Combinational in_ready from out_ready is forbidden.
- Ordering: strict FIFO; the skid packet is always emitted before any later input.
- Flush:
  - Next cycle: both entries invalid, out_valid=0, in_ready=1.
  - An input handshake in the same cycle as flush is discarded.
  - flush has priority over all transfers.
- Decode is combinational on in_instr and is registered on acceptance, never on output.
- Immediate, selected by opcode class:
  - I (OP_IMM, JALR, LOAD): sign-extend [31:20].
  - S (STORE): sign-extend {[31:25],[11:7]}.
  - B (BRANCH): sign-extend {[31],[7],[30:25],[11:8],0}, a 13-bit value.
  - U (LUI, AUIPC): {[31:12],12'b0}.
  - J (JAL): sign-extend {[31],[19:12],[20],[30:21],0}, a 21-bit value.
  - NONE (OP): imm=0.
  - All immediates are sign-extended to XLEN.
- illegal=1 when any of:
  - [1:0]!=11
  - unknown opcode
  - JALR funct3!=000
  - BRANCH funct3 010/011
  - LOAD funct3 011/110/111
  - STORE funct3>=011
  - OP_IMM shift (funct3 001/101) with funct7 not 0000000/0100000, or funct3=001 with funct7=0100000
  - OP funct7 not 0000000/0100000 (or 0000001 when ENABLE_M=1)
  - OP funct7=0100000 with funct3 not 000/101
  - MISC-MEM violating ENABLE_FENCE
- Illegal packets still flow and hold all decoded fields; downstream traps.
- is_muldiv=1 only for OP with funct7=0000001 and ENABLE_M=1.
- Reset mid-operation: held packets are lost; no partial output.

Decomposition:
- Shared package (isa_types) additions:
  - decode_packet_t
  - imm_fmt_t enum {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}
  - OPCODE_MISC_MEM added to opcode_t
  - FUNCT7_BASE / FUNCT7_ALT / FUNCT7_MULDIV constants
- Sub-modules:
  - One combinational sub-module, decode_comb (instr bits → decode_packet_t minus pc).
  - The stage module owns the handshake and buffering.

Test Plan:
- ADDI x1,x0,5 (0x00500093), pc=0x100, out_ready=1 → next cycle: out_valid=1, opcode=OP_IMM, rd=1, imm=5, imm_fmt=IMM_I, illegal=0, pc=0x100.
- BEQ x0,x0,-4 (0xFE000EE3) → imm=0xFFFFFFFC, imm_fmt=IMM_B. JAL x1,+2048 (0x001000EF) → imm=0x00000800.
- Backpressure: out_ready=0, present 3 back-to-back instructions → 2 accepted, in_ready=0 from cycle 2. Then release out_ready → outputs in original order, one per cycle, in_ready returns 1 one cycle after the first drain.
- Flush while FULL, with in_valid=1 in the same cycle → next cycle: out_valid=0, in_ready=1; the flushed-cycle instruction never appears.
- 0x02208033 (MUL x0,x1,x2): ENABLE_M=0 → illegal=1; ENABLE_M=1 → illegal=0, is_muldiv=1. 0x00000000 → illegal=1.
- Assert rst_n low asynchronously mid-stream while FULL → out_valid drops immediately, in_ready=1. After release, new input emerges with latency 1.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// RV32I decode types shared by the decode stage and its combinational decoder.
package decode_stage_pkg;

    localparam int DEC_XLEN = 32;

    typedef enum logic [6:0] {
        OPCODE_LOAD     = 7'b0000011,
        OPCODE_MISC_MEM = 7'b0001111,
        OPCODE_OP_IMM   = 7'b0010011,
        OPCODE_AUIPC    = 7'b0010111,
        OPCODE_STORE    = 7'b0100011,
        OPCODE_OP       = 7'b0110011,
        OPCODE_LUI      = 7'b0110111,
        OPCODE_BRANCH   = 7'b1100011,
        OPCODE_JALR     = 7'b1100111,
        OPCODE_JAL      = 7'b1101111
    } opcode_t;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_t;

    // opcode is kept as raw bits so illegal encodings survive into the packet
    typedef struct packed {
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [DEC_XLEN-1:0] imm;
        imm_fmt_t            imm_fmt;
        logic                is_muldiv;
        logic                illegal;
        logic [DEC_XLEN-1:0] pc;
    } decode_packet_t;

endpackage

// File: rtl/decode_stage_comb.sv
// Combinational RV32I field extraction, immediate selection and legality check.
import decode_stage_pkg::*;

module decode_stage_comb #(
    parameter bit ENABLE_M     = 1'b0,
    parameter bit ENABLE_FENCE = 1'b1
) (
    input  logic [31:0]    instr,
    output decode_packet_t pkt
);

    logic [2:0] f3;
    logic [6:0] f7;
    imm_fmt_t   fmt;

    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    always_comb begin
        pkt           = '0;
        fmt           = IMM_NONE;
        pkt.opcode    = instr[6:0];
        pkt.rd        = instr[11:7];
        pkt.rs1       = instr[19:15];
        pkt.rs2       = instr[24:20];
        pkt.funct3    = f3;
        pkt.funct7    = f7;
        pkt.illegal   = (instr[1:0] != 2'b11);

        case (instr[6:0])
            OPCODE_LOAD: begin
                fmt = IMM_I;
                if (f3 == 3'b011 || f3[2:1] == 2'b11) pkt.illegal = 1'b1;
            end
            OPCODE_MISC_MEM: begin
                if (!ENABLE_FENCE || f3[2:1] != 2'b00) pkt.illegal = 1'b1;
            end
            OPCODE_OP_IMM: begin
                fmt = IMM_I;
                if (f3 == 3'b001 && f7 != FUNCT7_BASE) pkt.illegal = 1'b1;
                if (f3 == 3'b101 && f7 != FUNCT7_BASE && f7 != FUNCT7_ALT) pkt.illegal = 1'b1;
            end
            OPCODE_AUIPC, OPCODE_LUI: fmt = IMM_U;
            OPCODE_STORE: begin
                fmt = IMM_S;
                if (f3 >= 3'b011) pkt.illegal = 1'b1;
            end
            OPCODE_OP: begin
                if (f7 == FUNCT7_MULDIV && ENABLE_M) begin
                    pkt.is_muldiv = 1'b1;
                end else if (f7 == FUNCT7_ALT) begin
                    if (f3 != 3'b000 && f3 != 3'b101) pkt.illegal = 1'b1;
                end else if (f7 != FUNCT7_BASE) begin
                    pkt.illegal = 1'b1;
                end
            end
            OPCODE_BRANCH: begin
                fmt = IMM_B;
                if (f3[2:1] == 2'b01) pkt.illegal = 1'b1;
            end
            OPCODE_JALR: begin
                fmt = IMM_I;
                if (f3 != 3'b000) pkt.illegal = 1'b1;
            end
            OPCODE_JAL: fmt = IMM_J;
            default: pkt.illegal = 1'b1;
        endcase

        pkt.imm_fmt = fmt;
        case (fmt)
            IMM_I:   pkt.imm = {{(DEC_XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S:   pkt.imm = {{(DEC_XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   pkt.imm = {{(DEC_XLEN-13){instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0};
            IMM_U:   pkt.imm = {{(DEC_XLEN-32){instr[31]}}, instr[31:12], 12'b0};
            IMM_J:   pkt.imm = {{(DEC_XLEN-21){instr[31]}}, instr[31], instr[19:12],
                                instr[20], instr[30:21], 1'b0};
            default: pkt.imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready on both sides and a one-deep skid entry.
// state | meaning
// EMPTY | main invalid, skid invalid; in_ready=1
// ONE   | main valid, skid invalid; in_ready=1
// FULL  | main valid, skid valid; in_ready=0
import decode_stage_pkg::*;

module decode_stage #(
    parameter int XLEN         = DEC_XLEN,
    parameter bit ENABLE_M     = 1'b0,
    parameter bit ENABLE_FENCE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output decode_packet_t  out_pkt
);

    decode_packet_t dec_pkt, in_pkt;
    decode_packet_t main_pkt, main_pkt_nxt, skid_pkt, skid_pkt_nxt;
    logic           main_valid, main_valid_nxt, skid_valid, skid_valid_nxt;
    logic           in_fire, out_fire;

    decode_stage_comb #(
        .ENABLE_M     (ENABLE_M),
        .ENABLE_FENCE (ENABLE_FENCE)
    ) u_comb (
        .instr (in_instr),
        .pkt   (dec_pkt)
    );

    always_comb begin
        in_pkt    = dec_pkt;
        in_pkt.pc = DEC_XLEN'(in_pc);
    end

    assign in_ready  = !skid_valid;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_pkt   = main_pkt;

    always_comb begin
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        main_pkt_nxt   = main_pkt;
        skid_pkt_nxt   = skid_pkt;
        if (flush) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
        end else if (!main_valid || out_fire) begin
            // main drains this cycle: the older skid packet always goes first
            if (skid_valid) begin
                main_pkt_nxt   = skid_pkt;
                main_valid_nxt = 1'b1;
                skid_valid_nxt = 1'b0;
            end else begin
                main_valid_nxt = in_fire;
                if (in_fire) main_pkt_nxt = in_pkt;
            end
        end else if (in_fire) begin
            skid_pkt_nxt   = in_pkt;
            skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_pkt   <= '0;
            skid_pkt   <= '0;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            main_pkt   <= main_pkt_nxt;
            skid_pkt   <= skid_pkt_nxt;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed ISA vectors plus randomized traffic against a queue model.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic in_ready_b, out_valid_b, in_ready_m, out_valid_m;
    decode_packet_t pkt_b, pkt_m;

    int checks = 0;
    int errors = 0;
    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_FENCE(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pkt(pkt_b)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_FENCE(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_m), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_pkt(pkt_m)
    );

    // Reference decode from the ISA rules, using arithmetic for the immediates.
    function automatic decode_packet_t ref_pkt(input logic [31:0] i, input logic [31:0] pc,
                                               input bit en_m);
        decode_packet_t p;
        int f3, f7;
        bit legal;
        logic signed [31:0] si;
        p = '0;
        p.opcode = i[6:0]; p.rd = i[11:7]; p.funct3 = i[14:12];
        p.rs1 = i[19:15]; p.rs2 = i[24:20]; p.funct7 = i[31:25]; p.pc = pc;
        f3 = int'(i[14:12]);
        f7 = int'(i[31:25]);
        si = $signed(i);
        legal = 1'b1;
        case (i[6:0])
            7'h03: begin p.imm_fmt = IMM_I; legal = f3 inside {0, 1, 2, 4, 5}; end
            7'h0F: legal = f3 inside {0, 1};
            7'h13: begin
                p.imm_fmt = IMM_I;
                if (f3 == 1) legal = (f7 == 0);
                else if (f3 == 5) legal = f7 inside {0, 32};
            end
            7'h17, 7'h37: p.imm_fmt = IMM_U;
            7'h23: begin p.imm_fmt = IMM_S; legal = (f3 < 3); end
            7'h33: begin
                legal = (f7 == 0) || (f7 == 32 && f3 inside {0, 5}) || (f7 == 1 && en_m);
                p.is_muldiv = (f7 == 1) && en_m;
            end
            7'h63: begin p.imm_fmt = IMM_B; legal = !(f3 inside {2, 3}); end
            7'h67: begin p.imm_fmt = IMM_I; legal = (f3 == 0); end
            7'h6F: p.imm_fmt = IMM_J;
            default: legal = 1'b0;
        endcase
        if (i[1:0] != 2'b11) legal = 1'b0;
        p.illegal = !legal;
        case (p.imm_fmt)
            IMM_I: p.imm = si >>> 20;
            IMM_S: p.imm = ((si >>> 25) <<< 5) + int'(i[11:7]);
            IMM_B: p.imm = (i[31] ? -4096 : 0) + int'(i[7]) * 2048
                           + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            IMM_U: p.imm = i & 32'hFFFF_F000;
            IMM_J: p.imm = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096
                           + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            default: p.imm = '0;
        endcase
        return p;
    endfunction

    // One clock: FIFO model of capacity 2 updated with the inputs seen at the edge.
    task automatic tick();
        bit do_pop, do_push, do_flush;
        logic [31:0] pi, pp;
        do_flush = flush;
        do_pop   = (q_instr.size() > 0) && out_ready;
        do_push  = in_valid && (q_instr.size() < 2);
        pi = in_instr;
        pp = in_pc;
        @(posedge clk);
        if (do_flush) begin
            q_instr.delete();
            q_pc.delete();
        end else begin
            if (do_pop) begin
                void'(q_instr.pop_front());
                void'(q_pc.pop_front());
            end
            if (do_push) begin
                q_instr.push_back(pi);
                q_pc.push_back(pp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid_b !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid_b); end
        checks++;
        if (in_ready_b !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready_b); end
        checks++;
        if (pkt_b !== '0) begin errors++; $display("FAIL reset_pkt got %h want 0", pkt_b); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_decode_vectors();
        logic [31:0] v_instr[7] = '{32'h0050_0093, 32'hFE00_0EE3, 32'h0010_00EF, 32'hFE20_AC23,
                                    32'h1234_52B7, 32'h0220_8033, 32'h0000_0000};
        logic [31:0] v_imm[7]   = '{32'h5, 32'hFFFF_FFFC, 32'h800, 32'hFFFF_FFF8,
                                    32'h1234_5000, 32'h0, 32'h0};
        imm_fmt_t    v_fmt[7]   = '{IMM_I, IMM_B, IMM_J, IMM_S, IMM_U, IMM_NONE, IMM_NONE};
        logic        v_ill_b[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        v_ill_m[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        v_md_m[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_instr = v_instr[k];
            in_pc    = 32'h100 + 32'(k * 4);
            tick();
            checks++;
            if (out_valid_b !== 1'b1 || pkt_b.pc !== 32'h100 + 32'(k * 4)) begin
                errors++;
                $display("FAIL vec%0d_valid_pc got %b/%h want 1/%h", k, out_valid_b, pkt_b.pc, 32'h100 + 32'(k * 4));
            end
            checks++;
            if (pkt_b.imm !== v_imm[k] || pkt_b.imm_fmt !== v_fmt[k]) begin
                errors++;
                $display("FAIL vec%0d_imm got %h/%0d want %h/%0d", k, pkt_b.imm, pkt_b.imm_fmt, v_imm[k], v_fmt[k]);
            end
            checks++;
            if (pkt_b.illegal !== v_ill_b[k] || pkt_b.is_muldiv !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_ill_base got %b/%b want %b/0", k, pkt_b.illegal, pkt_b.is_muldiv, v_ill_b[k]);
            end
            checks++;
            if (pkt_m.illegal !== v_ill_m[k] || pkt_m.is_muldiv !== v_md_m[k]) begin
                errors++;
                $display("FAIL vec%0d_ill_m got %b/%b want %b/%b", k, pkt_m.illegal, pkt_m.is_muldiv, v_ill_m[k], v_md_m[k]);
            end
            if (k == 0) begin
                checks++;
                if (pkt_b.opcode !== 7'h13 || pkt_b.rd !== 5'd1 || pkt_b.rs1 !== 5'd0) begin
                    errors++;
                    $display("FAIL addi_fields got op %h rd %0d rs1 %0d want 13/1/0", pkt_b.opcode, pkt_b.rd, pkt_b.rs1);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid_b !== 1'b0) begin errors++; $display("FAIL vec_drain got %b want 0", out_valid_b); end
    endtask

    task automatic test_backpressure();
        logic [31:0] seq[3] = '{32'h0010_0113, 32'h0020_0193, 32'h0030_0213};
        logic        rdy_exp[3] = '{1'b1, 1'b0, 1'b0};
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_instr = seq[k];
            in_pc    = 32'h200 + 32'(k * 4);
            tick();
            checks++;
            if (out_valid_b !== 1'b1 || in_ready_b !== rdy_exp[k] || pkt_b.pc !== 32'h200) begin
                errors++;
                $display("FAIL bp_fill%0d got v%b r%b pc %h want v1 r%b pc 200", k, out_valid_b, in_ready_b, pkt_b.pc, rdy_exp[k]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid_b !== 1'b1 || in_ready_b !== 1'b1 || pkt_b.pc !== 32'h204 || pkt_b.rd !== 5'd3) begin
            errors++;
            $display("FAIL bp_drain1 got v%b r%b pc %h rd %0d want v1 r1 pc 204 rd 3", out_valid_b, in_ready_b, pkt_b.pc, pkt_b.rd);
        end
        tick();
        checks++;
        if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain2 got v%b r%b want v0 r1", out_valid_b, in_ready_b);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_instr = 32'h0050_0093;
            in_pc    = 32'h300 + 32'(k * 4);
            tick();
        end
        flush    = 1'b1;
        in_pc    = 32'h308;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL flush_full got v%b r%b want v0 r1", out_valid_b, in_ready_b);
        end
        in_valid = 1'b1;
        in_pc    = 32'h30C;
        tick();
        flush = 1'b1;
        in_pc = 32'h310;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL flush_one got v%b r%b want v0 r1", out_valid_b, in_ready_b);
        end
        tick();
        checks++;
        if (out_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL flush_discard got v%b pc %h want v0", out_valid_b, pkt_b.pc);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_instr = 32'h0070_0093;
            in_pc    = 32'h400 + 32'(k * 4);
            tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q_instr.delete();
        q_pc.delete();
        checks++;
        if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1 || pkt_b !== '0) begin
            errors++;
            $display("FAIL async_reset got v%b r%b pkt %h want v0 r1 pkt 0", out_valid_b, in_ready_b, pkt_b);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h0090_0093;
        in_pc     = 32'h500;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid_b !== 1'b1 || pkt_b.pc !== 32'h500 || pkt_b.imm !== 32'h9) begin
            errors++;
            $display("FAIL post_reset got v%b pc %h imm %h want v1 pc 500 imm 9", out_valid_b, pkt_b.pc, pkt_b.imm);
        end
        tick();
    endtask

    task automatic test_random();
        logic [6:0] ops[11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
        logic [6:0] f7s[3] = '{7'h00, 7'h20, 7'h01};
        decode_packet_t exp_b, exp_m;
        bit exp_valid, exp_ready;
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 15) == 0);
            in_instr  = $urandom;
            if ($urandom_range(0, 3) != 0) in_instr[6:0] = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 1) == 1) in_instr[31:25] = f7s[$urandom_range(0, 2)];
            in_pc = $urandom & 32'hFFFF_FFFC;
            tick();
            exp_valid = (q_instr.size() > 0);
            exp_ready = (q_instr.size() < 2);
            checks++;
            if (out_valid_b !== exp_valid || in_ready_b !== exp_ready) begin
                errors++;
                $display("FAIL rand%0d_hs_base got v%b r%b want v%b r%b", n, out_valid_b, in_ready_b, exp_valid, exp_ready);
            end
            checks++;
            if (out_valid_m !== exp_valid || in_ready_m !== exp_ready) begin
                errors++;
                $display("FAIL rand%0d_hs_m got v%b r%b want v%b r%b", n, out_valid_m, in_ready_m, exp_valid, exp_ready);
            end
            if (exp_valid) begin
                exp_b = ref_pkt(q_instr[0], q_pc[0], 1'b0);
                exp_m = ref_pkt(q_instr[0], q_pc[0], 1'b1);
                checks++;
                if (pkt_b !== exp_b) begin
                    errors++;
                    $display("FAIL rand%0d_pkt_base got %h want %h (instr %h)", n, pkt_b, exp_b, q_instr[0]);
                end
                checks++;
                if (pkt_m !== exp_m) begin
                    errors++;
                    $display("FAIL rand%0d_pkt_m got %h want %h (instr %h)", n, pkt_m, exp_m, q_instr[0]);
                end
            end
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode_vectors();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
